// File: rtl/dbus_hold_pkg.sv
// Shared types for the data-bus hold stage.
//  dbus_req_t   : memory-stage / bus request (valid, addr, size, strobe, data)
//  dbus_resp_t  : bus / memory-stage response (addr_ok, data_ok, data)
//  hold_state_t : hold-stage FSM states
package dbus_hold_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SIZE_W = 2;     // log2 of access bytes: 0=1B .. 3=8B

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic              addr_ok;
        logic              data_ok;
        logic [DATA_W-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hold_state_t;

endpackage

// File: rtl/dbus_hold_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
//  clk    : clock
//  reset  : synchronous, active-low clear
//  en     : count this cycle
//  count  : registered count value
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dbus_hold.sv
// Hold stage between the memory stage request and the external data bus.
// Registers an accepted request, holds it on the bus until data_ok, returns
// a one-cycle response, and lets a flushed access finish on the bus silently.
//  clk, reset   : clock, synchronous active-low reset
//  flush        : pipeline flush, kills the response of the current access
//  in_req       : request from the memory stage
//  in_resp      : response to the memory stage
//  out_req      : request driven onto the data bus
//  out_resp     : response from the data bus
//  stall_o      : memory stage must hold
//  wait_cycles  : saturating count of cycles spent in BUSY/DRAIN
module dbus_hold
    import dbus_hold_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  dbus_req_t        in_req,
    output dbus_resp_t       in_resp,
    output dbus_req_t        out_req,
    input  dbus_resp_t       out_resp,
    output logic             stall_o,
    output logic [CNT_W-1:0] wait_cycles
);

    hold_state_t state;
    hold_state_t state_n;
    dbus_req_t   req_q;
    logic [DATA_W-1:0] data_q;
    logic        load_req;
    logic        cap_data;
    logic        bus_wait;

    // Bus-side address acknowledge carries no information for this stage.
    logic unused_addr_ok;
    assign unused_addr_ok = out_resp.addr_ok;

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            req_q  <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            if (load_req) begin
                req_q <= in_req;
            end
            if (cap_data) begin
                data_q <= out_resp.data;
            end
        end
    end

    // Next state and outputs.
    always_comb begin
        state_n       = state;
        load_req      = 1'b0;
        cap_data      = 1'b0;
        out_req       = req_q;
        out_req.valid = 1'b0;
        in_resp       = '0;
        in_resp.data  = data_q;
        stall_o       = 1'b0;

        unique case (state)
            IDLE: begin
                stall_o = in_req.valid;
                if (in_req.valid && !flush) begin
                    load_req = 1'b1;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                out_req.valid = 1'b1;
                stall_o       = 1'b1;
                if (out_resp.data_ok) begin
                    cap_data = 1'b1;
                    state_n  = flush ? IDLE : DONE;
                end else if (flush) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                // Access is orphaned: keep it on the bus, but the pipeline has moved on.
                out_req.valid = 1'b1;
                stall_o       = in_req.valid;
                if (out_resp.data_ok) begin
                    state_n = IDLE;
                end
            end
            DONE: begin
                in_resp.data_ok = !flush;
                in_resp.addr_ok = !flush;
                state_n         = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus_wait = (state == BUSY) || (state == DRAIN);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (bus_wait),
        .count (wait_cycles)
    );

endmodule

// File: tb/tb_dbus_hold.sv
// Bench for dbus_hold: random transactions, bus responder, response scoreboard.
module tb_dbus_hold;
    import dbus_hold_pkg::*;

    localparam int unsigned SM_W   = 3;
    localparam longint unsigned SM_MAX = (64'd1 << SM_W) - 64'd1;

    typedef struct {
        dbus_req_t   req;
        int          lat;
        logic [63:0] data;
    } bus_txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    dbus_req_t   in_req;
    dbus_resp_t  in_resp;
    dbus_req_t   out_req;
    dbus_resp_t  out_resp;
    logic        stall_o;
    logic [31:0] wait_cycles;

    dbus_resp_t  unused_sm_in_resp;
    dbus_req_t   unused_sm_out_req;
    logic        unused_sm_stall;
    logic [SM_W-1:0] sm_wait;

    bus_txn_t    bus_q[$];
    logic [63:0] exp_resp_q[$];
    longint unsigned total_wait;
    int          abort_req;
    int          n_checks;
    int          n_fail;

    always #5 clk = ~clk;

    dbus_hold #(.CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_req      (in_req),
        .in_resp     (in_resp),
        .out_req     (out_req),
        .out_resp    (out_resp),
        .stall_o     (stall_o),
        .wait_cycles (wait_cycles)
    );

    // Narrow-counter twin sharing all inputs, to reach saturation quickly.
    dbus_hold #(.CNT_W(SM_W)) dut_sm (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_req      (in_req),
        .in_resp     (unused_sm_in_resp),
        .out_req     (unused_sm_out_req),
        .out_resp    (out_resp),
        .stall_o     (unused_sm_stall),
        .wait_cycles (sm_wait)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic dbus_req_t rand_req();
        dbus_req_t q;
        q.valid  = 1'b1;
        q.addr   = $urandom;
        q.size   = 2'($urandom_range(0, 3));
        q.strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        q.data   = {$urandom, $urandom};
        return q;
    endfunction

    task automatic check_wait(input string tag);
        longint unsigned sm_exp;
        sm_exp = (total_wait >= SM_MAX) ? SM_MAX : total_wait;
        chk({tag, "_wait"}, 128'(wait_cycles), 128'(total_wait));
        chk({tag, "_wait_sat"}, 128'(sm_wait), 128'(sm_exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_req       = rand_req();
            in_req.valid = 1'b0;
            flush        = 1'($urandom_range(0, 1));
            #2;
            chk("idle_stall", 128'(stall_o), 128'(0));
            chk("idle_out_valid", 128'(out_req.valid), 128'(0));
            check_wait("idle");
        end
    endtask

    // flush_at: 0 none, -1 flush at acceptance (request ignored),
    // 1..lat flush in that bus cycle, lat+1 flush in the response cycle.
    task automatic run_txn(input dbus_req_t r_in, input int lat, input int flush_at,
                           input logic [63:0] d);
        dbus_req_t r;
        bus_txn_t  t;
        bit        busy;
        r       = r_in;
        r.valid = 1'b1;
        @(negedge clk);
        in_req = r;
        flush  = (flush_at < 0);
        #2;
        chk("accept_stall", 128'(stall_o), 128'(1));
        chk("accept_out_valid", 128'(out_req.valid), 128'(0));
        check_wait("accept");
        if (flush_at < 0) begin
            @(negedge clk);
            in_req.valid = 1'b0;
            flush        = 1'b0;
            #2;
            chk("flushed_req_ignored", 128'(out_req.valid), 128'(0));
            return;
        end
        t.req  = r;
        t.lat  = lat;
        t.data = d;
        bus_q.push_back(t);
        if (flush_at == 0) exp_resp_q.push_back(d);
        total_wait += longint'(lat);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            busy  = !(flush_at >= 1 && c > flush_at);
            flush = (c == flush_at);
            if (busy) begin
                in_req = r;
            end else begin
                in_req       = rand_req();
                in_req.valid = 1'($urandom_range(0, 1));
            end
            #2;
            chk(busy ? "busy_stall" : "drain_stall", 128'(stall_o),
                128'(busy ? 1'b1 : in_req.valid));
            chk("early_data_ok", 128'(in_resp.data_ok), 128'(0));
        end
        if (!(flush_at >= 1 && flush_at <= lat)) begin
            @(negedge clk);
            in_req = r;
            flush  = (flush_at == lat + 1);
            #2;
            chk("done_stall", 128'(stall_o), 128'(0));
            chk("done_out_valid", 128'(out_req.valid), 128'(0));
            chk("done_data_ok", 128'(in_resp.data_ok), 128'(flush_at == 0));
        end
    endtask

    task automatic reset_mid_busy();
        dbus_req_t r;
        bus_txn_t  t;
        r = rand_req();
        @(negedge clk);
        in_req = r;
        flush  = 1'b0;
        t.req  = r;
        t.lat  = 5;
        t.data = '0;
        bus_q.push_back(t);
        @(negedge clk);
        #2;
        chk("rst_pre_stall", 128'(stall_o), 128'(1));
        chk("rst_pre_valid", 128'(out_req.valid), 128'(1));
        @(negedge clk);
        reset        = 1'b0;
        abort_req++;
        in_req.valid = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        total_wait = 0;
        #2;
        chk("rst_out_valid", 128'(out_req.valid), 128'(0));
        chk("rst_stall", 128'(stall_o), 128'(0));
        chk("rst_data_ok", 128'(in_resp.data_ok), 128'(0));
        check_wait("rst");
    endtask

    // Bus responder: checks the held request and answers after the chosen latency.
    initial begin : bus_side
        bus_txn_t cur;
        int       cnt;
        bit       active;
        int       abort_seen;
        active     = 1'b0;
        cnt        = 0;
        abort_seen = 0;
        out_resp   = '0;
        forever begin
            @(posedge clk);
            #1;
            out_resp.data_ok = 1'b0;
            out_resp.addr_ok = 1'($urandom_range(0, 1));
            out_resp.data    = {$urandom, $urandom};
            if (abort_seen != abort_req) begin
                abort_seen = abort_req;
                active     = 1'b0;
            end
            if (out_req.valid) begin
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected_req", 128'(out_req.valid), 128'(0));
                    end else begin
                        cur    = bus_q.pop_front();
                        active = 1'b1;
                        cnt    = 0;
                    end
                end
                if (active) begin
                    chk("bus_req_held", 128'(out_req), 128'(cur.req));
                    cnt++;
                    if (cnt == cur.lat) begin
                        out_resp.data_ok = 1'b1;
                        out_resp.data    = cur.data;
                        active           = 1'b0;
                    end
                end
            end else if (active) begin
                chk("bus_valid_dropped", 128'(out_req.valid), 128'(1));
                active = 1'b0;
            end
        end
    end

    // Response monitor: every in_resp.data_ok must match the oldest expected response.
    initial begin : resp_mon
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (in_resp.data_ok) begin
                if (exp_resp_q.size() == 0) begin
                    chk("resp_unexpected", 128'(in_resp.data_ok), 128'(0));
                end else begin
                    e = exp_resp_q.pop_front();
                    chk("resp_data", 128'(in_resp.data), 128'(e));
                    chk("resp_addr_ok", 128'(in_resp.addr_ok), 128'(1));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        dbus_req_t r;
        int        lat;
        int        fa;
        n_checks   = 0;
        n_fail     = 0;
        total_wait = 0;
        abort_req  = 0;
        reset      = 1'b0;
        flush      = 1'b0;
        in_req     = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_out_req", 128'(out_req), 128'(0));
        chk("reset_data_ok", 128'(in_resp.data_ok), 128'(0));
        chk("reset_stall", 128'(stall_o), 128'(0));
        check_wait("reset");
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Load, 8 bytes, two wait cycles.
        r        = '0;
        r.addr   = 32'h8000_0010;
        r.size   = 2'd3;
        r.strobe = 8'h00;
        run_txn(r, 2, 0, 64'hDEAD_BEEF_0123_4567);
        idle(1);
        chk("load_wait_cycles", 128'(wait_cycles), 128'(2));

        // Store with upper-half strobe.
        r        = '0;
        r.addr   = 32'h8000_0020;
        r.size   = 2'd3;
        r.strobe = 8'hF0;
        r.data   = 64'h1122_3344_0000_0000;
        run_txn(r, 3, 0, {$urandom, $urandom});

        // Zero-wait bus, back to back.
        for (int i = 0; i < 3; i++) run_txn(rand_req(), 1, 0, {$urandom, $urandom});

        // Flush one cycle after acceptance, bus answers three cycles later.
        run_txn(rand_req(), 4, 1, {$urandom, $urandom});
        run_txn(rand_req(), 1, 0, {$urandom, $urandom});

        // Flush in the response cycle and flush together with bus data_ok.
        run_txn(rand_req(), 2, 3, {$urandom, $urandom});
        run_txn(rand_req(), 2, 2, {$urandom, $urandom});
        run_txn(rand_req(), 1, -1, '0);

        // Long access drives the narrow counter into saturation.
        run_txn(rand_req(), 5, 0, {$urandom, $urandom});
        idle(1);
        chk("narrow_counter_saturated", 128'(sm_wait), 128'(SM_MAX));

        for (int i = 0; i < 40; i++) begin
            lat = $urandom_range(1, 6);
            case ($urandom_range(0, 9))
                6:       fa = -1;
                7, 8, 9: fa = $urandom_range(1, lat + 1);
                default: fa = 0;
            endcase
            run_txn(rand_req(), lat, fa, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        reset_mid_busy();
        for (int i = 0; i < 5; i++) begin
            lat = $urandom_range(1, 4);
            run_txn(rand_req(), lat, 0, {$urandom, $urandom});
        end
        idle(3);
        chk("resp_queue_empty", 128'(exp_resp_q.size()), 128'(0));
        chk("bus_queue_empty", 128'(bus_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
